fir_interpolator: RTL and testbench
===================================

// Module: fir_interpolator
// PURPOSE
//  Polyphase FIR interpolator by L; the upsampling counterpart of the polyphase decimator.
//  - Accepts one input sample per L*D clk cycles.
//  - Emits L output samples, one every D cycles.
//  - Output phase p = sum_k h[p+k*L]*x[n-k].
//  - One time-shared MAC; coefficients loaded through the same c_we/c_addr/c_in port as the decimator.
// PARAMETERS
//  ORD          255  filter order; ORD+1 taps, ORD+1 divisible by L
//  L            8    interpolation factor (power of 2)
//  D            100  clk cycles per output sample; must be >= POLY_NUM+3
//  COEFF_SIZE   16   coefficient width, signed Q1.(COEFF_SIZE-1)
//  SAMPLE_SIZE  16   sample width, signed Q1.(SAMPLE_SIZE-1)
//  (derived) POLY_NUM=(ORD+1)/L taps per phase; ACC_W=SAMPLE_SIZE+COEFF_SIZE+$clog2(POLY_NUM)
// PORTS
//  clk        in   1                  single clock, all logic on posedge
//  nrst       in   1                  reset, synchronous, active-low
//  valid_in   in   1                  input sample strobe
//  ready_in   out  1                  block can accept a sample this cycle
//  din        in   SAMPLE_SIZE        input sample, signed
//  valid_out  out  1                  one-cycle strobe per output sample
//  dout       out  SAMPLE_SIZE        output sample, signed, held between strobes
//  c_we       in   1                  coefficient write enable
//  c_addr     in   $clog2(ORD+1)      coefficient index 0..ORD (natural tap order)
//  c_in       in   COEFF_SIZE         coefficient data
// BEHAVIOUR
//  Reset values (nrst low at a clk edge): valid_out=0, dout=0, ready_in=1, FSM=IDLE, wr_ptr=0, fill=0.
//  Delay line is not cleared on reset; taps k>=fill contribute 0. fill saturates at POLY_NUM.
//  FSM: IDLE -> MAC -> HOLD -> (MAC of next phase | IDLE).
//  - IDLE: ready_in=1. On valid_in&&!c_we:
//      - write din at wr_ptr; wr_ptr wraps at POLY_NUM; fill++.
//      - phase p=0, slot timer=0, go to MAC.
//  - MAC (slot cycles 1..POLY_NUM): acc clears at slot cycle 1, then accumulates
//    coef[p+k*L]*x[wr_ptr-k] for k=0..POLY_NUM-1. 1-cycle memory read latency.
//  - HOLD: wait until slot timer reaches D-1, then:
//      - dout<=sat(round(acc)), valid_out<=1 (high for exactly 1 cycle);
//      - p<L-1: p++, timer=0, back to MAC; p==L-1: go to IDLE.
//  Latency: sample accepted in cycle t0 -> valid_out in cycles t0+(p+1)*D, p=0..L-1.
//  ready_in=1 again in cycle t0+L*D; an input accepted in that cycle gives gapless output.
//  valid_in while ready_in=0: sample dropped; no state change.
//  Arithmetic:
//  - acc is signed ACC_W wide, no internal overflow possible.
//  - Result = acc>>>(COEFF_SIZE-1), rounded half-up (add 1 at bit COEFF_SIZE-2).
//  - Saturate to [-2^(SAMPLE_SIZE-1), 2^(SAMPLE_SIZE-1)-1].
//  c_we:
//  - Writes coef[c_addr]<=c_in the same cycle; allowed at any time; forces ready_in=0.
//  - If asserted in MAC/HOLD: abort to IDLE next cycle; no further valid_out for that sample.
//    Delay line and fill are kept.
//  - A new sample is accepted no earlier than the cycle after c_we deasserts.
//  c_we and valid_in in the same cycle: the coefficient write wins, the sample is dropped.
// CONFIGURATION
//  FIR_INTERP_GAIN_EN defined:
//  - Rounding input is acc<<<$clog2(L), compensating the 1/L zero-stuffing gain.
//  - Saturation is applied after the shift.
//  FIR_INTERP_GAIN_EN undefined: no shift; unity coefficient gain (current decimator convention).
// STRUCTURE
//  fir_pkg:
//  - function round_sat(acc) -> SAMPLE_SIZE, shared with fir_decimator output stage.
//  - localparam helpers: POLY_NUM, ACC_W.
//  Sub-module fir_interp_datapath:
//  - coefficient RAM (ORD+1 x COEFF_SIZE) and sample ring (POLY_NUM x SAMPLE_SIZE);
//  - multiply-accumulate register and fill masking.
//  Top level holds the FSM, slot timer, pointers and handshake.
// TESTING  (config ORD=15, L=4, D=8, POLY_NUM=4, 16-bit)
//  1 Impulse: coef[i]=0x0100*(i+1); din=0x4000 then 3x 0x0000.
//    -> 16 dout values 0x0080,0x0100,...,0x0800 in order.
//  2 Saturation: all coef=0x7FFF; 4x din=0x7FFF -> last 4 dout=0x7FFF.
//    Then 4x din=0x8000 -> dout=0x8000.
//  3 Timing: accept at t0 -> valid_out at t0+8,16,24,32; ready_in=0 t0+1..t0+31, 1 at t0+32.
//    valid_in at t0+5 dropped; output unchanged vs. test 1.
//  4 c_we one cycle at t0+12 -> no valid_out at t0+16..32; ready_in=1 at t0+14.
//    Next impulse uses the new coefficient.
//  5 nrst low one cycle at t0+10 -> cycle t0+11: valid_out=0, dout=0, ready_in=1.
//    Next impulse outputs match test 1 (fill masking).
//  6 FIR_INTERP_GAIN_EN defined, test 1 stimulus -> dout 0x0200,0x0400,...,0x2000.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM type, derived-size helpers and the rounding/saturating output stage
// used by the polyphase FIR blocks.
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } fir_state_e;

  function automatic int poly_num(input int ord, input int l);
    return (ord + 1) / l;
  endfunction

  function automatic int acc_width(input int sample_size, input int coeff_size, input int taps);
    return sample_size + coeff_size + $clog2(taps);
  endfunction

  // Result is already clamped to out_bits, so callers keep only the low out_bits bits.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int frac_bits,
                                                    input int out_bits,
                                                    input int gain_shift);
    logic signed [63:0] v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_bits - 1));
    v     = (acc <<< gain_shift) + (64'sd1 <<< (frac_bits - 1));
    v     = v >>> frac_bits;
    if (v > max_v) begin
      v = max_v;
    end else if (v < min_v) begin
      v = min_v;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_interp_datapath.sv
// fir_interp_datapath: coefficient RAM, sample ring with registered reads, and the
// fill-masked multiply-accumulate register of the interpolator.
`default_nettype none

module fir_interp_datapath
  import fir_pkg::*;
#(
  parameter int ORD         = 255,
  parameter int POLY_NUM    = 32,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16,
  parameter int ACC_W       = 37,
  parameter int CA_W        = 8,
  parameter int PTR_W       = 5
) (
  input  logic                          clk,
  input  logic                          coef_we,
  input  logic [CA_W-1:0]               coef_waddr,
  input  logic signed [COEFF_SIZE-1:0]  coef_wdata,
  input  logic                          samp_we,
  input  logic [PTR_W-1:0]              samp_waddr,
  input  logic signed [SAMPLE_SIZE-1:0] samp_wdata,
  input  logic                          rd_en,
  input  logic [CA_W-1:0]               coef_raddr,
  input  logic [PTR_W-1:0]              samp_raddr,
  input  logic                          tap_live,
  input  logic                          acc_clr,
  input  logic                          acc_en,
  output logic signed [ACC_W-1:0]       acc
);

  localparam int PROD_W = COEFF_SIZE + SAMPLE_SIZE;

  logic signed [COEFF_SIZE-1:0]  coef_mem [ORD+1];
  logic signed [SAMPLE_SIZE-1:0] samp_mem [POLY_NUM];

  logic signed [COEFF_SIZE-1:0]  coef_q;
  logic signed [SAMPLE_SIZE-1:0] samp_q;
  logic                          live_q;
  logic signed [PROD_W-1:0]      prod;

  always_ff @(posedge clk) begin
    if (coef_we) begin
      coef_mem[coef_waddr] <= coef_wdata;
    end
    if (samp_we) begin
      samp_mem[samp_waddr] <= samp_wdata;
    end
  end

  // The liveness flag travels with the read data so masking lines up with the MAC cycle.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      coef_q <= coef_mem[coef_raddr];
      samp_q <= samp_mem[samp_raddr];
      live_q <= tap_live;
    end
  end

  assign prod = PROD_W'(coef_q) * PROD_W'(samp_q);

  always_ff @(posedge clk) begin
    if (acc_clr) begin
      acc <= '0;
    end else if (acc_en && live_q) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_interpolator.sv
// fir_interpolator: polyphase FIR interpolator by L with one time-shared MAC.
// Define FIR_INTERP_GAIN_EN to scale results by L, compensating the zero-stuffing gain.
`default_nettype none

module fir_interpolator
  import fir_pkg::*;
#(
  parameter int ORD         = 255,
  parameter int L           = 8,
  parameter int D           = 100,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic signed [SAMPLE_SIZE-1:0] din,
  output logic                          valid_out,
  output logic signed [SAMPLE_SIZE-1:0] dout,
  input  logic                          c_we,
  input  logic [$clog2(ORD+1)-1:0]      c_addr,
  input  logic signed [COEFF_SIZE-1:0]  c_in
);

  localparam int POLY_NUM = poly_num(ORD, L);
  localparam int ACC_W    = acc_width(SAMPLE_SIZE, COEFF_SIZE, POLY_NUM);
  localparam int CA_W     = $clog2(ORD + 1);
  localparam int PTR_W    = (POLY_NUM > 1) ? $clog2(POLY_NUM) : 1;
  localparam int FILL_W   = $clog2(POLY_NUM + 1);
  localparam int TW       = $clog2(D);
  localparam int PH_W     = (L > 1) ? $clog2(L) : 1;
`ifdef FIR_INTERP_GAIN_EN
  localparam int GAIN_SH  = $clog2(L);
`else
  localparam int GAIN_SH  = 0;
`endif

  localparam logic [TW-1:0]     T_CLR      = TW'(1);
  localparam logic [TW-1:0]     T_LAST_RD  = TW'(POLY_NUM);
  localparam logic [TW-1:0]     T_LAST_ACC = TW'(POLY_NUM + 1);
  localparam logic [TW-1:0]     T_END      = TW'(D - 1);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(L - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(POLY_NUM - 1);
  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(POLY_NUM);

  fir_state_e state;
  fir_state_e next_state;

  logic [TW-1:0]     timer;
  logic [PH_W-1:0]   phase;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] fill;
  logic              cwe_d;
  logic              accept;
  logic              rd_en;
  logic              acc_clr;
  logic              acc_en;
  logic [FILL_W-1:0] tap;
  logic              tap_live;
  logic [CA_W-1:0]   coef_raddr;
  logic [PTR_W-1:0]  samp_raddr;
  logic signed [ACC_W-1:0] acc;
  int                newest;
  int                slot;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Slot cycle t (1..POLY_NUM) reads tap t-1; its product lands in the acc one cycle later.
  always_comb begin
    next_state = state;
    ready_in   = 1'b0;
    accept     = 1'b0;
    rd_en      = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_in = !c_we && !cwe_d;
        if (ready_in && valid_in) begin
          accept     = 1'b1;
          next_state = S_MAC;
        end
      end
      S_MAC: begin
        rd_en   = (timer >= T_CLR) && (timer <= T_LAST_RD);
        acc_clr = (timer == T_CLR);
        acc_en  = (timer > T_CLR) && (timer <= T_LAST_ACC);
        if (timer == T_LAST_ACC) begin
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (timer == T_END) begin
          next_state = (phase == PH_LAST) ? S_IDLE : S_MAC;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (c_we) begin
      next_state = S_IDLE;
    end
  end

  always_comb begin
    tap        = FILL_W'(timer - T_CLR);
    newest     = (wr_ptr == '0) ? (POLY_NUM - 1) : (int'(wr_ptr) - 1);
    slot       = newest - int'(tap);
    if (slot < 0) begin
      slot = slot + POLY_NUM;
    end
    samp_raddr = PTR_W'(slot);
    coef_raddr = CA_W'(int'(phase) + int'(tap) * L);
    tap_live   = (tap < fill);
  end

  // The accept cycle counts as slot cycle 0, so the first phase starts at timer 1.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      timer     <= '0;
      phase     <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      cwe_d     <= 1'b0;
      valid_out <= 1'b0;
      dout      <= '0;
    end else begin
      cwe_d     <= c_we;
      valid_out <= 1'b0;
      if (accept) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
        timer <= T_CLR;
        phase <= '0;
      end else if (state != S_IDLE) begin
        if ((state == S_HOLD) && (timer == T_END)) begin
          if (!c_we) begin
            valid_out <= 1'b1;
            dout      <= SAMPLE_SIZE'(round_sat(64'(acc), COEFF_SIZE - 1, SAMPLE_SIZE, GAIN_SH));
          end
          timer <= '0;
          phase <= phase + 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  fir_interp_datapath #(
    .ORD         (ORD),
    .POLY_NUM    (POLY_NUM),
    .COEFF_SIZE  (COEFF_SIZE),
    .SAMPLE_SIZE (SAMPLE_SIZE),
    .ACC_W       (ACC_W),
    .CA_W        (CA_W),
    .PTR_W       (PTR_W)
  ) u_datapath (
    .clk        (clk),
    .coef_we    (c_we),
    .coef_waddr (c_addr),
    .coef_wdata (c_in),
    .samp_we    (accept),
    .samp_waddr (wr_ptr),
    .samp_wdata (din),
    .rd_en      (rd_en),
    .coef_raddr (coef_raddr),
    .samp_raddr (samp_raddr),
    .tap_live   (tap_live),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .acc        (acc)
  );

endmodule

`default_nettype wire

// File: tb/tb_fir_interpolator.sv
// tb_fir_interpolator: randomized self-checking bench against a direct convolution model.
`default_nettype none

module tb_fir_interpolator;

  localparam int ORD = 15;
  localparam int L   = 4;
  localparam int D   = 8;
  localparam int P   = 4;
  localparam int N   = ORD + 1;
`ifdef FIR_INTERP_GAIN_EN
  localparam logic [15:0] IMP_LAST = 16'h2000;
`else
  localparam logic [15:0] IMP_LAST = 16'h0800;
`endif

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               valid_in = 1'b0;
  logic               ready_in;
  logic signed [15:0] din = '0;
  logic               valid_out;
  logic signed [15:0] dout;
  logic               c_we = 1'b0;
  logic [3:0]         c_addr = '0;
  logic signed [15:0] c_in = '0;

  int checks = 0;
  int errors = 0;

  int m_coef [N];
  int m_hist [P];
  int m_fill = 0;

  fir_interpolator #(
    .ORD(ORD), .L(L), .D(D), .COEFF_SIZE(16), .SAMPLE_SIZE(16)
  ) dut (
    .clk(clk), .nrst(nrst), .valid_in(valid_in), .ready_in(ready_in), .din(din),
    .valid_out(valid_out), .dout(dout), .c_we(c_we), .c_addr(c_addr), .c_in(c_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic signed [15:0] x);
    for (int i = P - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int'(x);
    if (m_fill < P) m_fill++;
  endtask

  // Output phase p = sum_k h[p+kL]*x[n-k], then round half-up, (gain), saturate.
  function automatic int model_out(input int p);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < P; k++) begin
      if (k < m_fill) acc += longint'(m_coef[p + k*L]) * longint'(m_hist[k]);
    end
`ifdef FIR_INTERP_GAIN_EN
    acc = acc * L;
`endif
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic load_coefs(input int mode);
    logic signed [15:0] v;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: v = 16'(256 * (i + 1));
        1: v = 16'sh7FFF;
        default: v = 16'($urandom);
      endcase
      c_we = 1'b1; c_addr = 4'(i); c_in = v;
      m_coef[i] = int'(v);
      tick();
    end
    c_we = 1'b0;
    tick();
  endtask

  task automatic process_sample(input logic signed [15:0] x, input bit drop);
    int p;
    int e;
    p = 0;
    checks++;
    if (ready_in !== 1'b1) begin
      errors++; $display("FAIL ready_at_accept: got %b want 1", ready_in);
    end
    valid_in = 1'b1; din = x;
    model_accept(x);
    for (int off = 1; off <= L*D; off++) begin
      tick();
      valid_in = 1'b0;
      if (drop && off == 5) begin
        valid_in = 1'b1; din = 16'($urandom);
      end
      checks++;
      if (ready_in !== (off == L*D)) begin
        errors++; $display("FAIL ready_window off=%0d: got %b want %b", off, ready_in, off == L*D);
      end
      checks++;
      if (valid_out !== (off % D == 0)) begin
        errors++; $display("FAIL valid_out_timing off=%0d: got %b want %b", off, valid_out, off % D == 0);
      end
      if (off % D == 0) begin
        e = model_out(p);
        p++;
        checks++;
        if (dout !== 16'(e)) begin
          errors++; $display("FAIL dout phase=%0d: got %h want %h", p - 1, dout, 16'(e));
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick(); tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_in); end
    nrst = 1'b1;
    m_fill = 0;
    tick();
  endtask

  task automatic test_impulse();
    load_coefs(0);
    process_sample(16'sh4000, 1'b0);
    for (int i = 0; i < 3; i++) process_sample(16'sh0000, 1'b0);
    checks++;
    if (dout !== IMP_LAST) begin errors++; $display("FAIL impulse_last: got %h want %h", dout, IMP_LAST); end
  endtask

  task automatic test_saturation();
    load_coefs(1);
    for (int i = 0; i < 4; i++) process_sample(16'sh7FFF, 1'b0);
    checks++;
    if (dout !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", dout); end
    for (int i = 0; i < 4; i++) process_sample(16'sh8000, 1'b0);
    checks++;
    if (dout !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h want 8000", dout); end
  endtask

  task automatic test_timing_drop();
    load_coefs(0);
    process_sample(16'sh4000, 1'b1);
    for (int i = 0; i < 3; i++) process_sample(16'sh0000, 1'b1);
  endtask

  task automatic test_nrst_midrun();
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL nrst_ready_pre: got %b want 1", ready_in); end
    valid_in = 1'b1; din = 16'sh4000;
    model_accept(16'sh4000);
    for (int off = 1; off <= 11; off++) begin
      tick();
      valid_in = 1'b0;
      if (off == 8) begin
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL nrst_pre_strobe: got %b want 1", valid_out); end
      end
      if (off == 10) nrst = 1'b0;
      if (off == 11) begin
        nrst = 1'b1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL nrst_valid_out: got %b want 0", valid_out); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL nrst_dout: got %h want 0000", dout); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL nrst_ready: got %b want 1", ready_in); end
      end
    end
    m_fill = 0;
    tick();
    process_sample(16'sh4000, 1'b0);
    for (int i = 0; i < 3; i++) process_sample(16'sh0000, 1'b0);
    checks++;
    if (dout !== IMP_LAST) begin errors++; $display("FAIL nrst_impulse_last: got %h want %h", dout, IMP_LAST); end
  endtask

  task automatic test_cwe_abort();
    logic signed [15:0] nv;
    nv = 16'($urandom_range(1, 32767));
    valid_in = 1'b1; din = 16'sh4000;
    model_accept(16'sh4000);
    for (int off = 1; off <= L*D + 2; off++) begin
      tick();
      valid_in = 1'b0;
      c_we = 1'b0;
      if (off == 8) begin
        checks++;
        if (valid_out !== 1'b1 || dout !== 16'(model_out(0))) begin
          errors++; $display("FAIL abort_first_out: got %b/%h want 1/%h", valid_out, dout, 16'(model_out(0)));
        end
      end
      if (off == 12) begin
        c_we = 1'b1; c_addr = 4'd1; c_in = nv;
        m_coef[1] = int'(nv);
        #1;
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("FAIL abort_ready_cwe: got %b want 0", ready_in); end
      end
      if (off == 13) begin
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("FAIL abort_ready_t13: got %b want 0", ready_in); end
      end
      if (off == 14) begin
        checks++;
        if (ready_in !== 1'b1) begin errors++; $display("FAIL abort_ready_t14: got %b want 1", ready_in); end
      end
      if (off >= 13) begin
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL abort_no_output off=%0d: got %b want 0", off, valid_out); end
      end
    end
    process_sample(16'sh4000, 1'b0);
    for (int i = 0; i < 3; i++) process_sample(16'sh0000, 1'b0);
  endtask

  task automatic test_collision();
    logic signed [15:0] cv;
    logic [3:0]         ca;
    cv = 16'($urandom);
    ca = 4'($urandom);
    valid_in = 1'b1; din = 16'($urandom);
    c_we = 1'b1; c_addr = ca; c_in = cv;
    m_coef[ca] = int'(cv);
    #1;
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b want 0", ready_in); end
    tick();
    valid_in = 1'b0; c_we = 1'b0;
    for (int off = 1; off <= D + 2; off++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0) begin errors++; $display("FAIL collide_no_output off=%0d: got %b want 0", off, valid_out); end
    end
    for (int i = 0; i < 4; i++) process_sample(16'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    load_coefs(2);
    for (int i = 0; i < 8; i++) process_sample(16'($urandom), 1'($urandom));
  endtask

  initial begin
    for (int i = 0; i < P; i++) m_hist[i] = 0;
    for (int i = 0; i < N; i++) m_coef[i] = 0;
    test_reset();
    test_impulse();
    test_saturation();
    test_timing_drop();
    test_nrst_midrun();
    test_cwe_abort();
    test_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
